kbd_event_queue: RTL and testbench

KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

---
 rtl/kbd_event_queue.sv | 133 +++++++++++++
 tb/tb_kbd_event_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_queue.sv
// Keyboard event FIFO feeding the matrix write port. A release can be held
// until the CPU has scanned its row (build with KBD_EVT_HOLD_EN).
module kbd_event_queue #(
  parameter int DEPTH     = 8,
  parameter int MIN_SCANS = 2
) (
  input  logic        sys_clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  evt_data_i,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [3:0]  row_sel_i,
  input  logic        row_read_i,
  output logic [16:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        wr_en_o,
  output logic        overflow_o
);

  // state | meaning
  // IDLE  | waiting for a queued event; pops the head when one exists
  // LOAD  | head event registered; decide hold or write
  // HOLD  | release waiting for enough CPU scans of its row
  // WRITE | one-cycle matrix write strobe is out
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, WRITE} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  state_t       state;
  logic [7:0]   fifo_mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, push;
  logic [7:0]   evt_q;
  logic [7:0]   shadow [16];
  logic [7:0]   row_next;
  logic [3:0]   evt_row;
  logic [2:0]   evt_col;
  logic         evt_press;
  logic         hold_req;
  logic         go_write;

  assign evt_row   = evt_q[3:0];
  assign evt_col   = evt_q[6:4];
  assign evt_press = evt_q[7];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready is forced low while reset is held, even though the FIFO is empty then.
  assign evt_ready_o = reset_n_i && !full;
  assign push        = evt_valid_i && evt_ready_o;

  always_comb begin
    row_next          = shadow[evt_row];
    row_next[evt_col] = ~evt_press;
  end

`ifdef KBD_EVT_HOLD_EN
  logic [2:0] scan_cnt [16];

  assign hold_req = !evt_press && (scan_cnt[evt_row] < 3'(MIN_SCANS));

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < 16; r++) scan_cnt[r] <= 3'(MIN_SCANS);
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (go_write && evt_press && (evt_row == 4'(r)))
          scan_cnt[r] <= 3'd0;
        else if (row_read_i && (row_sel_i == 4'(r)) && (scan_cnt[r] < 3'(MIN_SCANS)))
          scan_cnt[r] <= scan_cnt[r] + 3'd1;
      end
    end
  end
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{row_sel_i, row_read_i};
  assign hold_req = 1'b0;
`endif

  assign go_write = ((state == LOAD) || (state == HOLD)) && !hold_req;

  always_ff @(posedge sys_clk_i) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= evt_data_i;
  end

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (evt_valid_i && !evt_ready_o) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      evt_q     <= 8'h00;
      wr_en_o   <= 1'b0;
      wr_addr_o <= 17'h0E800;
      wr_data_o <= 8'hFF;
      for (int r = 0; r < 16; r++) shadow[r] <= 8'hFF;
    end else begin
      wr_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            evt_q  <= fifo_mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
            state  <= LOAD;
          end
        end
        LOAD, HOLD: begin
          if (go_write) begin
            state           <= WRITE;
            wr_en_o         <= 1'b1;
            wr_addr_o       <= 17'h0E800 + {13'd0, evt_row};
            wr_data_o       <= row_next;
            shadow[evt_row] <= row_next;
          end else begin
            state <= HOLD;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Self-checking bench for kbd_event_queue: directed latency/hold/reset steps
// plus a randomized flood checked against an in-order scoreboard.
module tb_kbd_event_queue;
  localparam int DEPTH     = 8;
  localparam int MIN_SCANS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  evt_data = 8'h00;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic [3:0]  row_sel = 4'h0;
  logic        row_read = 1'b0;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        overflow;

  always #5 clk = ~clk;

  kbd_event_queue #(.DEPTH(DEPTH), .MIN_SCANS(MIN_SCANS)) dut (
    .sys_clk_i  (clk),
    .reset_n_i  (rst_n),
    .evt_data_i (evt_data),
    .evt_valid_i(evt_valid),
    .evt_ready_o(evt_ready),
    .row_sel_i  (row_sel),
    .row_read_i (row_read),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_en_o    (wr_en),
    .overflow_o (overflow)
  );

  int          tests = 0;
  int          fails = 0;
  int          n_writes = 0;
  logic [7:0]  last_data;
  logic [16:0] last_addr;
  logic [7:0]  exp_q [$];
  logic [7:0]  mshadow [16];

  logic [7:0]  d;
  int          w0, w1, occ;
  logic        exp_rdy, ovf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int r = 0; r < 16; r++) mshadow[r] = 8'hFF;
  endtask

  // Advance one clock and score any matrix write against the expected order.
  task automatic tick();
    logic [7:0] e;
    logic [7:0] row;
    @(posedge clk);
    #1;
    if (wr_en) begin
      n_writes++;
      last_data = wr_data;
      last_addr = wr_addr;
      check("write_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        row = mshadow[e[3:0]];
        row[e[6:4]] = ~e[7];
        mshadow[e[3:0]] = row;
        check("wr_addr", 32'(wr_addr), 32'(17'h0E800) + 32'(e[3:0]));
        check("wr_data", 32'(wr_data), 32'(row));
      end
    end
  endtask

  task automatic send(input logic [7:0] ev);
    evt_data  = ev;
    evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    exp_q.push_back(ev);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check(tag, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic scan(input logic [3:0] r);
    row_sel  = r;
    row_read = 1'b1;
    tick();
    row_read = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 17'h0E800);
    check("rst_wr_data", wr_data, 8'hFF);
    check("rst_overflow", overflow, 0);
    check("rst_ready", evt_ready, 0);
    #11 rst_n = 1'b1;
    #1;
    check("ready_after_rst", evt_ready, 1);
    tick();
    tick();

    // Minimum latency of a single press
    send(8'h83);
    check("lat_e0", wr_en, 0);
    tick();
    check("lat_e1", wr_en, 0);
    tick();
    check("lat_e2", wr_en, 1);
    check("p83_addr", wr_addr, 17'h0E803);
    check("p83_data", wr_data, 8'hFE);
    tick();
    check("lat_e3", wr_en, 0);
    drain(20, "drain_p83");

    // Two presses on one row accumulate
    send(8'hF5);
    drain(20, "drain_f5");
    send(8'hA5);
    drain(20, "drain_a5");
    check("a5_addr", last_addr, 17'h0E805);
    check("a5_data", last_data, 8'h7B);

`ifdef KBD_EVT_HOLD_EN
    // Release waits for MIN_SCANS reads of its own row
    w0 = n_writes;
    send(8'h83);
    send(8'h03);
    repeat (12) tick();
    check("hold_only_press", n_writes - w0, 1);
    scan(4'd2);
    repeat (4) tick();
    check("hold_other_row", n_writes - w0, 1);
    scan(4'd3);
    repeat (4) tick();
    check("hold_one_scan", n_writes - w0, 1);
    scan(4'd3);
    drain(10, "hold_release");
    check("hold_writes", n_writes - w0, 2);
    check("rel_data", last_data, 8'hFF);
    check("rel_addr", last_addr, 17'h0E803);

    // Head-of-line blocking fills the FIFO and overflows
    send(8'h84);
    drain(20, "drain_p84");
    send(8'h04);
    repeat (4) tick();
    w0 = n_writes;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom) | 8'h80;
      evt_data  = d;
      evt_valid = 1'b1;
      check("hol_ready", evt_ready, 32'(i < 8));
      tick();
      if (i < 8) exp_q.push_back(d);
    end
    evt_valid = 1'b0;
    check("hol_no_write", n_writes - w0, 0);
    check("hol_overflow", overflow, 1);
    check("hol_ready_full", evt_ready, 0);
    scan(4'd4);
    scan(4'd4);
    drain(100, "hol_drain");
    check("hol_writes", n_writes - w0, 9);

    // Reset while a release sits in HOLD with another event queued behind it
    send(8'h86);
    send(8'h06);
    repeat (8) tick();
    send(8'h87);
`else
    // Back-to-back press/release with no scans writes at minimum spacing
    w0 = n_writes;
    send(8'h83);
    send(8'h03);
    check("nh_e1", wr_en, 0);
    tick();
    check("nh_e2", wr_en, 1);
    check("nh_e2_data", wr_data, 8'hFE);
    tick();
    check("nh_e3", wr_en, 0);
    tick();
    check("nh_e4", wr_en, 0);
    tick();
    check("nh_e5", wr_en, 1);
    check("nh_e5_data", wr_data, 8'hFF);
    drain(10, "nh_drain");
    check("nh_writes", n_writes - w0, 2);

    // Reset while an event sits in LOAD
    send(8'h86);
    tick();
`endif
    w1 = n_writes;
    #2 rst_n = 1'b0;
    model_reset();
    #2;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_addr", wr_addr, 17'h0E800);
    check("mid_rst_data", wr_data, 8'hFF);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_ready", evt_ready, 0);
    #10 rst_n = 1'b1;
    #1;
    check("mid_rst_ready_exit", evt_ready, 1);
    repeat (6) tick();
    check("rst_no_write", n_writes - w1, 0);
    send(8'h80);
    drain(20, "drain_p80");
    check("p80_addr", last_addr, 17'h0E800);
    check("p80_data", last_data, 8'hFE);
    // Counters restart saturated, so a release needs no scans
    send(8'h16);
    drain(10, "rel_after_rst");
    check("rel_after_rst_addr", last_addr, 17'h0E806);
    check("rel_after_rst_data", last_data, 8'hFF);

    // Randomized flood: one offer per cycle, drain one event per three cycles
    occ   = 0;
    ovf_m = 1'b0;
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
`ifdef KBD_EVT_HOLD_EN
      d[7] = 1'b1;
`endif
      evt_data  = d;
      evt_valid = 1'b1;
      exp_rdy   = (occ < DEPTH);
      check("flood_ready", evt_ready, exp_rdy);
      check("flood_overflow", overflow, ovf_m);
      tick();
      if (exp_rdy) begin
        exp_q.push_back(d);
        occ++;
      end else begin
        ovf_m = 1'b1;
      end
      if ((k % 3) == 1 && occ > 0) occ--;
    end
    evt_valid = 1'b0;
    check("flood_overflow_end", overflow, ovf_m);
    drain(200, "flood_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
